// File: rtl/complex_accumulator_array.sv
// complex_accumulator_array: element-wise burst accumulator of a 4x4x4 complex array, result pulsed to the IFFT
module complex_accumulator_array #(
  parameter int DIM = 4,
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic [DIM*DIM*DIM*2*WIDTH-1:0] in,
  input  logic start,
  input  logic stop,
  output logic [DIM*DIM*DIM*2*WIDTH-1:0] out,
  output logic output_valid
);
  localparam int E = DIM * DIM * DIM;
  localparam int N = E * 2 * WIDTH;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_next;
  logic [N-1:0] acc, acc_sum;
  logic emit, add;
  genvar g;
  generate
    for (g = 0; g < E; g++) begin : g_add
      assign acc_sum[g*2*WIDTH +: WIDTH] = acc[g*2*WIDTH +: WIDTH] + in[g*2*WIDTH +: WIDTH];
      assign acc_sum[g*2*WIDTH+WIDTH +: WIDTH] = acc[g*2*WIDTH+WIDTH +: WIDTH] + in[g*2*WIDTH+WIDTH +: WIDTH];
    end
  endgenerate
  // stop in ACCUM completes a burst; start always (re)loads, taking priority over the return to IDLE
  always_comb begin
    emit = state == ACCUM && stop;
    add = state == ACCUM && !start && !stop;
    state_next = start ? ACCUM : (emit ? IDLE : state);
  end
  // accumulator, result register and valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      out <= '0;
      output_valid <= 1'b0;
    end else begin
      state <= state_next;
      output_valid <= emit;
      if (emit) out <= acc;
      if (start) acc <= in;
      else if (add) acc <= acc_sum;
    end
  end
endmodule

// File: tb/tb_complex_accumulator_array.sv
// tb_complex_accumulator_array: scoreboard bench for the burst accumulator
module tb_complex_accumulator_array;
  localparam int E = 64;
  localparam int N = E * 64;
  typedef logic [N-1:0] vec_t;
  logic clk = 0, reset = 1, start = 0, stop = 0, output_valid;
  vec_t in = '0, out;
  vec_t m_acc = '0;
  logic m_active = 0;
  vec_t exp_q[$];
  int checks = 0, errors = 0, pushes = 0, pulses = 0;
  complex_accumulator_array dut (.clk(clk), .reset(reset), .in(in), .start(start), .stop(stop), .out(out), .output_valid(output_valid));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic vec_t fill(input logic [31:0] r, input logic [31:0] i);
    vec_t v;
    for (int e = 0; e < E; e++) v[e*64 +: 64] = {r, i};
    return v;
  endfunction
  function automatic vec_t ramp(input int k);
    vec_t v;
    for (int e = 0; e < E; e++) v[e*64 +: 64] = {32'(k * (e + 1)), 32'(-(k * (e + 1)))};
    return v;
  endfunction
  function automatic vec_t vadd(input vec_t a, input vec_t b);
    vec_t v;
    for (int e = 0; e < E; e++) begin
      v[e*64+32 +: 32] = a[e*64+32 +: 32] + b[e*64+32 +: 32];
      v[e*64 +: 32] = a[e*64 +: 32] + b[e*64 +: 32];
    end
    return v;
  endfunction
  task automatic step(input logic s, input logic p, input vec_t v);
    start = s;
    stop = p;
    in = v;
    if (m_active && p) begin
      exp_q.push_back(m_acc);
      pushes++;
    end
    if (s) begin
      m_acc = v;
      m_active = 1;
    end else if (m_active && p) m_active = 0;
    else if (m_active) m_acc = vadd(m_acc, v);
    @(posedge clk);
    #1;
    start = 0;
    stop = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    m_acc = '0;
    m_active = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  always @(negedge clk) begin
    if (!reset && output_valid) begin
      pulses++;
      if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
      else begin
        automatic vec_t x = exp_q.pop_front();
        automatic int bad = 0;
        for (int e = E - 1; e >= 0; e--) if (out[e*64 +: 64] !== x[e*64 +: 64]) bad = e;
        check($sformatf("sb_out_e%0d", bad), out[bad*64 +: 64], x[bad*64 +: 64]);
      end
    end
  end
  initial begin
    do_reset();
    do_reset();
    check("rst_valid", 64'(output_valid), 64'd0);
    check("rst_out_e0", out[63:0], 64'd0);
    check("rst_out_e63", out[N-1 -: 64], 64'd0);
    step(1, 0, ramp(1));
    step(0, 0, ramp(1));
    step(0, 0, ramp(1));
    step(0, 1, '0);
    check("b3_valid", 64'(output_valid), 64'd1);
    check("b3_e0", out[63:0], {32'd3, -32'd3});
    check("b3_e63", out[N-1 -: 64], {32'd192, -32'd192});
    step(0, 0, '0);
    check("b3_valid_drop", 64'(output_valid), 64'd0);
    step(1, 0, fill(7, 9));
    step(0, 1, fill(99, 99));
    check("b1_e5", out[5*64 +: 64], {32'd7, 32'd9});
    step(0, 0, '0);
    check("b1_valid_drop", 64'(output_valid), 64'd0);
    step(1, 0, fill(32'h7FFFFFFF, 32'hFFFFFFFF));
    step(0, 0, fill(32'h00000001, 32'h00000001));
    step(0, 1, '0);
    check("wrap_e9", out[9*64 +: 64], {32'h80000000, 32'h00000000});
    step(1, 0, fill(3, 3));
    step(0, 0, fill(7, 7));
    step(1, 1, fill(4, 4));
    check("bb_a_valid", 64'(output_valid), 64'd1);
    check("bb_a_e0", out[63:0], {32'd10, 32'd10});
    step(0, 0, fill(4, 4));
    step(0, 1, '0);
    check("bb_b_e0", out[63:0], {32'd8, 32'd8});
    step(1, 0, fill(1, 1));
    step(0, 0, fill(1, 1));
    do_reset();
    step(0, 1, '0);
    check("rmb_valid", 64'(output_valid), 64'd0);
    check("rmb_out", out[63:0], 64'd0);
    step(1, 0, fill(5, 5));
    step(0, 1, '0);
    check("fresh_e20", out[20*64 +: 64], {32'd5, 32'd5});
    step(0, 0, '0);
    step(0, 1, fill(1, 1));
    check("spur_valid", 64'(output_valid), 64'd0);
    check("spur_out", out[20*64 +: 64], {32'd5, 32'd5});
    repeat (3) @(posedge clk);
    #1;
    check("sb_pending", 64'(exp_q.size()), 64'd0);
    check("pulse_count", 64'(pulses), 64'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
